// File: rtl/ahb_reg_bridge_if.sv
// ---------------------------------------------------------------------------
// ahb_reg_bridge_if
// Purpose : groups the AHB-Lite slave-side signals of ahb_reg_bridge.
// Signals : hsels/haddrs/htranss/hsizes/hwrites/hreadys/hwdatas driven by the
//           interconnect (master modport), hreadyouts/hresps/hrdatas driven
//           back by the slave (slave modport).
// ---------------------------------------------------------------------------
interface ahb_reg_bridge_if #(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 32
);
    logic                 hsels;
    logic [ADDRWIDTH-1:0] haddrs;
    logic [1:0]           htranss;
    logic [2:0]           hsizes;
    logic                 hwrites;
    logic                 hreadys;
    logic [DATAWIDTH-1:0] hwdatas;
    logic                 hreadyouts;
    logic                 hresps;
    logic [DATAWIDTH-1:0] hrdatas;

    modport master (
        output hsels, haddrs, htranss, hsizes, hwrites, hreadys, hwdatas,
        input  hreadyouts, hresps, hrdatas
    );

    modport slave (
        input  hsels, haddrs, htranss, hsizes, hwrites, hreadys, hwdatas,
        output hreadyouts, hresps, hrdatas
    );
endinterface

// File: rtl/ahb_reg_bridge.sv
// ---------------------------------------------------------------------------
// ahb_reg_bridge
// Purpose : AHB-Lite slave to register-bus bridge with configurable data
//           width, programmable read latency (RD_WAIT) and two-cycle ERROR
//           responses for oversize, misaligned or out-of-range transfers.
// Ports   : hclk, hresetn (async, active-low)
//           bus          - AHB-Lite slave side (ahb_reg_bridge_if.slave)
//           addr         - registered transfer address
//           read_en      - one-cycle read strobe
//           write_en     - one-cycle write strobe
//           byte_strobe  - active byte lanes of the transfer
//           wdata        - write data (straight from hwdatas)
//           rdata        - register-file read data, valid RD_WAIT cycles
//                          after read_en
// ---------------------------------------------------------------------------
module ahb_reg_bridge #(
    parameter int                   ADDRWIDTH  = 12,
    parameter int                   DATAWIDTH  = 32,
    parameter int                   RD_WAIT    = 0,
    parameter logic [ADDRWIDTH-1:0] ADDR_LIMIT = 12'hFFF,
    localparam int                  NSTRB      = DATAWIDTH / 8
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    ahb_reg_bridge_if.slave      bus,
    output logic [ADDRWIDTH-1:0] addr,
    output logic                 read_en,
    output logic                 write_en,
    output logic [NSTRB-1:0]     byte_strobe,
    output logic [DATAWIDTH-1:0] wdata,
    input  logic [DATAWIDTH-1:0] rdata
);
    localparam int         OFFW      = $clog2(NSTRB);
    localparam logic [2:0] WAIT_INIT = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RDW, S_ERR1, S_ERR2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [NSTRB-1:0]       strb_q, strb_d;

    logic                   req;
    logic                   illegal;
    logic [OFFW-1:0]        misalign;
    logic [OFFW-1:0]        offset;
    logic [NSTRB-1:0]       strb_calc;
    logic                   ready_o;
    logic                   unused_bits;

    // Only htranss[1] separates NONSEQ/SEQ from IDLE/BUSY.
    assign unused_bits = bus.htranss[0];

    assign req    = bus.hsels & bus.hreadys & bus.htranss[1];
    assign offset = bus.haddrs[OFFW-1:0];

    // Address bit gi must be zero whenever the transfer is wider than 2**gi
    // bytes. Bits at or above OFFW only matter for oversize transfers, which
    // are rejected by the size check anyway.
    for (genvar gi = 0; gi < OFFW; gi++) begin : g_align
        assign misalign[gi] = bus.haddrs[gi] & (3'(gi) < bus.hsizes);
    end

    // A lane is active when it falls in the same naturally aligned block
    // of 2**hsizes bytes as the transfer address.
    for (genvar gi = 0; gi < NSTRB; gi++) begin : g_strb
        localparam logic [OFFW-1:0] LANE = OFFW'(gi);
        assign strb_calc[gi] = ((LANE >> bus.hsizes) == (offset >> bus.hsizes));
    end

    assign illegal = (bus.hsizes > 3'(OFFW)) | (|misalign) | (bus.haddrs > ADDR_LIMIT);

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
        end
    end

    // Next-state logic. A new address phase is only taken when this cycle
    // drives hreadyouts high, i.e. the final cycle of the current data phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        case (state_q)
            S_ERR1: state_d = S_ERR2;
            S_RD: begin
                if (!ready_o) begin
                    state_d = S_RDW;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_RDW: begin
                if (!ready_o) cnt_d = cnt_q - 3'd1;
            end
            default: ;
        endcase
        if (ready_o) begin
            if (!req) begin
                state_d = S_IDLE;
            end else if (illegal) begin
                state_d = S_ERR1;
            end else begin
                state_d = bus.hwrites ? S_WR : S_RD;
                addr_d  = bus.haddrs;
                strb_d  = strb_calc;
            end
        end
    end

    // Output logic, decoded from state so reset clears it immediately.
    always_comb begin
        ready_o  = 1'b1;
        bus.hresps = 1'b0;
        read_en  = 1'b0;
        write_en = 1'b0;
        case (state_q)
            S_WR:   write_en = 1'b1;
            S_RD: begin
                read_en = 1'b1;
                ready_o = (RD_WAIT == 0);
            end
            S_RDW:  ready_o = (cnt_q == 3'd0);
            S_ERR1: begin
                bus.hresps = 1'b1;
                ready_o    = 1'b0;
            end
            S_ERR2: bus.hresps = 1'b1;
            default: ;
        endcase
        bus.hrdatas = '0;
        if ((state_q == S_RD || state_q == S_RDW) && ready_o) bus.hrdatas = rdata;
    end

    assign bus.hreadyouts = ready_o;
    assign addr           = addr_q;
    assign byte_strobe    = strb_q;
    assign wdata          = bus.hwdatas;
endmodule
